argmax_layer: RTL and testbench
===============================

# argmax_layer

Parametrised final classification layer: adds two signed score vectors element-wise (e.g. two partial-sum banks of the last dense layer), then finds the index and value of the largest sum through a pipelined comparator tree. It accepts one vector per clock, has fixed latency, and sits at the network output, feeding the result/readout logic. It generalises the fixed 12-class, single-shot compare layer to any class count, signed/saturating arithmetic, full throughput and a max-value output.

## Interface
Parameters:
- N_CLASS, 12, number of classes (≥1)
- DATA_W, `data_len, element width, two's complement
- SAT, 1, 1 = saturating add, 0 = wrapping add
- IDX_W, $clog2(N_CLASS) (min 1), derived, index width; not to be overridden

Ports:
- clk  in  1  clock; the block has one clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  d1/d2 carry a vector this cycle
- d1  in  N_CLASS*DATA_W  score vector A; element i at [i*DATA_W +: DATA_W]
- d2  in  N_CLASS*DATA_W  score vector B, same packing
- out_valid  out  1  one-cycle pulse per accepted vector
- out_idx  out  IDX_W  index of the maximum sum
- out_max  out  DATA_W  maximum sum value (signed)

## Operation
- Stage 0 (add): s[i] = d1[i] + d2[i], signed.
  - SAT=1: an overflow clamps to 2^(DATA_W-1)-1 (positive) or -2^(DATA_W-1) (negative).
  - SAT=0: the result wraps modulo 2^DATA_W.
- Each sum is tagged with its index i.
- Tree stages 1..D, where D = ceil(log2 N_CLASS):
  - Each stage compares adjacent pairs (2k, 2k+1) signed and forwards the winner's value and index.
  - An odd element left over at a stage passes through unchanged, registered.
- Tie rule: on equal values the lower index wins at every stage, so the overall result is the lowest index among the equal maxima.
- Each stage carries a valid bit. Stage data registers load only when that stage's incoming valid is 1; otherwise they hold.
- out_idx and out_max update only with out_valid, and hold the last result between pulses.
- No backpressure. The downstream consumer must take each out_valid pulse.
- N_CLASS=1: there are no tree stages. The result is idx 0 and max s[0].

## Timing
- Latency LAT = 1 + D cycles: a vector sampled on the rising edge with in_valid=1 produces out_valid=1 for one cycle, LAT edges later.
  - N_CLASS=12: LAT=5.
  - N_CLASS=1: LAT=1.
- Throughput: one vector per cycle. Back-to-back in_valid produces back-to-back out_valid, in order, with no loss.
- Gaps in in_valid are reproduced exactly in out_valid, delayed by LAT.
- Reset (asynchronous, any time): all valid bits clear, out_valid=0, out_idx=0, out_max=0, and stage data clears to 0.
  - In-flight vectors are discarded; no out_valid is produced for them after reset release.
  - The first vector accepted after release appears LAT cycles later.
- The path has no combinational dependence from inputs to outputs; every output is driven from a register.

## Structure
- The shared header (num_data.v) supplies `data_len, which is the DATA_W default. It also holds any shared saturation-limit macros; nothing block-specific goes there.
- Sub-module argmax_stage holds one tree level. Its parameters are element count M, DATA_W and IDX_W. It takes valid + M value/index pairs and produces valid + ceil(M/2) pairs.
- argmax_layer holds the adder/saturation stage and instantiates D argmax_stage levels in a generate loop.

## Test plan
- N_CLASS=12, DATA_W=16, SAT=1; d1[i]=i, d2[i]=100, single in_valid pulse -> out_valid exactly 5 cycles later, out_idx=11, out_max=111.
- Saturation: d1[3]=32767, d2[3]=10, all other sums 0 -> out_idx=3, out_max=32767. With SAT=0 the same stimulus gives sum[3]=-32759, so out_idx=0 and out_max=0 (tie at 0, lowest index).
- Signed and tie: all sums -5 except sums[4]=sums[9]=-1 -> out_idx=4, out_max=-1.
- Streaming: 20 consecutive random vectors with in_valid=1, then a 3-cycle gap, then 5 more -> 25 pulses, in order, each matching a reference model, with the gap pattern preserved at LAT=5.
- Reset mid-flight: 3 vectors issued, rst_n pulsed low 2 cycles later -> outputs go to 0 immediately, no out_valid after release, and a new vector yields a correct result 5 cycles after acceptance.
- Parameter sweep N_CLASS ∈ {1, 2, 3, 7, 16}: verify LAT = 1 + ceil(log2 N), the odd pass-through, and that max at the last index and at index 0 are both found.

Source files
------------

// File: rtl/argmax_layer_pkg.sv
// rtl/argmax_layer_pkg.sv - shared constants and tree-geometry helpers for argmax_layer
// Purpose: default element width plus elaboration-time functions describing the
//          comparator tree (index width, depth, per-level element count and the
//          offset of each level inside the flattened level bus).
// Ports:   none (package).
package argmax_layer_pkg;

   localparam int DATA_LEN = 16;

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int tree_depth(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   // Element count at tree level l (level 0 = adder outputs).
   function automatic int lvl_size(input int n, input int l);
      int s;
      s = n;
      for (int k = 0; k < l; k++) begin
         s = (s + 1) / 2;
      end
      return s;
   endfunction

   // First element position of level l when all levels are packed back to back.
   function automatic int lvl_off(input int n, input int l);
      int o;
      o = 0;
      for (int k = 0; k < l; k++) begin
         o = o + lvl_size(n, k);
      end
      return o;
   endfunction

endpackage

// File: rtl/argmax_layer_stage.sv
// rtl/argmax_layer_stage.sv - one registered level of the argmax comparator tree
// Purpose: compares adjacent pairs (2k, 2k+1) as signed values and registers the
//          winner's value and index; an odd leftover element is registered unchanged.
//          Ties go to the even (lower-index) element. Data loads only with valid_i.
// Ports:   clk, rst_n     clock, asynchronous active-low reset
//          valid_i        incoming level carries a vector
//          val_i, idx_i   M packed values / indices
//          valid_o        registered valid
//          val_o, idx_o   ceil(M/2) packed values / indices (registered)
module argmax_stage #(
   parameter int M      = 2,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              valid_i,
   input  logic [M*DATA_W-1:0]               val_i,
   input  logic [M*IDX_W-1:0]                idx_i,
   output logic                              valid_o,
   output logic [((M+1)/2)*DATA_W-1:0]       val_o,
   output logic [((M+1)/2)*IDX_W-1:0]        idx_o
);

   localparam int MO = (M + 1) / 2;

   logic                     valid_q;
   logic [MO*DATA_W-1:0]     val_d, val_q;
   logic [MO*IDX_W-1:0]      idx_d, idx_q;
   logic signed [DATA_W-1:0] va, vb;

   always_comb begin
      val_d = '0;
      idx_d = '0;
      va    = '0;
      vb    = '0;
      for (int k = 0; k < M / 2; k++) begin
         va = val_i[(2*k)*DATA_W +: DATA_W];
         vb = val_i[(2*k+1)*DATA_W +: DATA_W];
         // Strictly greater: equal values keep the lower index.
         if (vb > va) begin
            val_d[k*DATA_W +: DATA_W] = vb;
            idx_d[k*IDX_W +: IDX_W]   = idx_i[(2*k+1)*IDX_W +: IDX_W];
         end else begin
            val_d[k*DATA_W +: DATA_W] = va;
            idx_d[k*IDX_W +: IDX_W]   = idx_i[(2*k)*IDX_W +: IDX_W];
         end
      end
      if (M % 2 == 1) begin
         val_d[(MO-1)*DATA_W +: DATA_W] = val_i[(M-1)*DATA_W +: DATA_W];
         idx_d[(MO-1)*IDX_W +: IDX_W]   = idx_i[(M-1)*IDX_W +: IDX_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         val_q   <= '0;
         idx_q   <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            val_q <= val_d;
            idx_q <= idx_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign val_o   = val_q;
   assign idx_o   = idx_q;

endmodule

// File: rtl/argmax_layer.sv
// rtl/argmax_layer.sv - element-wise add of two score vectors followed by a pipelined argmax tree
// Purpose: stage 0 registers s[i] = d1[i] + d2[i] (saturating when SAT=1, wrapping
//          otherwise) tagged with index i; D = ceil(log2 N_CLASS) argmax_stage levels
//          reduce to one winner. Latency 1 + D, one vector per clock, no backpressure.
// Ports:   clk, rst_n           clock, asynchronous active-low reset
//          in_valid, d1, d2     input vector pair, element i at [i*DATA_W +: DATA_W]
//          out_valid            one-cycle pulse per accepted vector
//          out_idx, out_max     index and value of the maximum sum (held between pulses)
module argmax_layer
   import argmax_layer_pkg::*;
#(
   parameter int N_CLASS = 12,
   parameter int DATA_W  = DATA_LEN,
   parameter int SAT     = 1,
   parameter int IDX_W   = idx_width(N_CLASS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [N_CLASS*DATA_W-1:0] d1,
   input  logic [N_CLASS*DATA_W-1:0] d2,
   output logic                      out_valid,
   output logic [IDX_W-1:0]          out_idx,
   output logic [DATA_W-1:0]         out_max
);

   localparam int D     = tree_depth(N_CLASS);
   localparam int TOTAL = lvl_off(N_CLASS, D + 1);
   localparam int OUT_O = lvl_off(N_CLASS, D);

   // Every tree level packed back to back; level 0 is the adder register.
   logic [TOTAL*DATA_W-1:0] all_val;
   logic [TOTAL*IDX_W-1:0]  all_idx;
   logic [D:0]              all_valid;

   logic                      valid0_q;
   logic [N_CLASS*DATA_W-1:0] sum_d, sum_q;
   logic [DATA_W:0]           wide;

   always_comb begin
      sum_d = '0;
      wide  = '0;
      for (int i = 0; i < N_CLASS; i++) begin
         // One extra sign bit: overflow shows as the top two bits disagreeing.
         wide = {d1[i*DATA_W + DATA_W - 1], d1[i*DATA_W +: DATA_W]}
              + {d2[i*DATA_W + DATA_W - 1], d2[i*DATA_W +: DATA_W]};
         if ((SAT != 0) && (wide[DATA_W] != wide[DATA_W-1])) begin
            sum_d[i*DATA_W +: DATA_W] = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                     : {1'b0, {(DATA_W-1){1'b1}}};
         end else begin
            sum_d[i*DATA_W +: DATA_W] = wide[DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid0_q <= 1'b0;
         sum_q    <= '0;
      end else begin
         valid0_q <= in_valid;
         if (in_valid) begin
            sum_q <= sum_d;
         end
      end
   end

   assign all_val[0 +: N_CLASS*DATA_W] = sum_q;
   assign all_valid[0]                 = valid0_q;

   for (genvar i = 0; i < N_CLASS; i++) begin : g_tag
      assign all_idx[i*IDX_W +: IDX_W] = IDX_W'(i);
   end

   for (genvar l = 0; l < D; l++) begin : g_lvl
      localparam int MI = lvl_size(N_CLASS, l);
      localparam int MO = lvl_size(N_CLASS, l + 1);
      localparam int OI = lvl_off(N_CLASS, l);
      localparam int OO = lvl_off(N_CLASS, l + 1);

      argmax_stage #(
         .M      (MI),
         .DATA_W (DATA_W),
         .IDX_W  (IDX_W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid_i (all_valid[l]),
         .val_i   (all_val[OI*DATA_W +: MI*DATA_W]),
         .idx_i   (all_idx[OI*IDX_W +: MI*IDX_W]),
         .valid_o (all_valid[l+1]),
         .val_o   (all_val[OO*DATA_W +: MO*DATA_W]),
         .idx_o   (all_idx[OO*IDX_W +: MO*IDX_W])
      );
   end

   // The last level registers hold their data between pulses, so they drive the outputs directly.
   assign out_valid = all_valid[D];
   assign out_max   = all_val[OUT_O*DATA_W +: DATA_W];
   assign out_idx   = all_idx[OUT_O*IDX_W +: IDX_W];

endmodule

// File: tb/tb_argmax_layer.sv
// tb/tb_argmax_layer.sv - scoreboard bench driving several argmax_layer configurations in parallel
module tb_argmax_layer;

   localparam int NCFG = 7;
   localparam int CFG_N   [NCFG] = '{12, 12, 1, 2, 3, 7, 16};
   localparam int CFG_SAT [NCFG] = '{1, 0, 1, 1, 1, 1, 1};
   localparam int CFG_LAT [NCFG] = '{5, 5, 1, 2, 3, 4, 5};

   typedef struct {
      int due;
      int idx;
      int mx;
   } exp_t;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic signed [15:0] va [16];
   logic signed [15:0] vb [16];
   logic signed [15:0] na [16];
   logic signed [15:0] nb [16];

   logic ov   [NCFG];
   int   oidx [NCFG];
   int   omax [NCFG];

   exp_t q [NCFG][$];
   int   last_idx [NCFG];
   int   last_mx  [NCFG];
   int   cyc;
   int   n_cmp;
   int   n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int N  = CFG_N[g];
      localparam int IW = (N <= 1) ? 1 : $clog2(N);
      logic [N*16-1:0]    d1_w;
      logic [N*16-1:0]    d2_w;
      logic               o_valid;
      logic [IW-1:0]      o_idx;
      logic signed [15:0] o_max;

      for (genvar i = 0; i < N; i++) begin : pk
         assign d1_w[i*16 +: 16] = va[i];
         assign d2_w[i*16 +: 16] = vb[i];
      end

      argmax_layer #(
         .N_CLASS (N),
         .DATA_W  (16),
         .SAT     (CFG_SAT[g])
      ) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .d1        (d1_w),
         .d2        (d2_w),
         .out_valid (o_valid),
         .out_idx   (o_idx),
         .out_max   (o_max)
      );

      assign ov[g]   = o_valid;
      assign oidx[g] = int'(o_idx);
      assign omax[g] = int'(o_max);
   end

   // Linear-scan reference: first strictly greater value wins.
   function automatic void model(input int n, input int sat, output int bi, output int bm);
      int s;
      logic [15:0] w;
      bi = 0;
      bm = 0;
      for (int i = 0; i < n; i++) begin
         s = int'(va[i]) + int'(vb[i]);
         if (sat != 0) begin
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
         end else begin
            w = s[15:0];
            s = int'($signed(w));
         end
         if (i == 0 || s > bm) begin
            bi = i;
            bm = s;
         end
      end
   endfunction

   task automatic fill(input int a_base, input int a_step, input int b_val);
      for (int i = 0; i < 16; i++) begin
         na[i] = 16'(a_base + a_step * i);
         nb[i] = 16'(b_val);
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 16; i++) begin
         na[i] = 16'($urandom_range(0, 65535));
         nb[i] = 16'($urandom_range(0, 65535));
      end
   endtask

   // hand=1: configs 0 (SAT) and 1 (wrap) use the hand-computed results given.
   task automatic send(input bit hand, input int hi0, input int hm0, input int hi1, input int hm1);
      exp_t e;
      int bi, bm;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         va[i] = na[i];
         vb[i] = nb[i];
      end
      in_valid = 1'b1;
      for (int g = 0; g < NCFG; g++) begin
         model(CFG_N[g], CFG_SAT[g], bi, bm);
         if (hand && g == 0) begin
            bi = hi0;
            bm = hm0;
         end
         if (hand && g == 1) begin
            bi = hi1;
            bm = hm1;
         end
         e.due = cyc + CFG_LAT[g];
         e.idx = bi;
         e.mx  = bm;
         q[g].push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int g = 0; g < NCFG; g++) begin
         last_idx[g] = 0;
         last_mx[g]  = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      for (int g = 0; g < NCFG; g++) begin
         if (!rst_n) begin
            n_cmp++;
            if (ov[g] !== 1'b0 || oidx[g] != 0 || omax[g] != 0) begin
               n_bad++;
               $display("FAIL reset_state cfg%0d: valid=%0b idx=%0d max=%0d, required 0/0/0",
                        g, ov[g], oidx[g], omax[g]);
            end
            q[g].delete();
            last_idx[g] = 0;
            last_mx[g]  = 0;
         end else begin
            while (q[g].size() > 0 && q[g][0].due < cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL missing_pulse cfg%0d: no out_valid at cycle %0d, required idx=%0d max=%0d",
                        g, q[g][0].due, q[g][0].idx, q[g][0].mx);
               void'(q[g].pop_front());
            end
            n_cmp++;
            if (ov[g] === 1'b1) begin
               if (q[g].size() == 0 || q[g][0].due != cyc) begin
                  n_bad++;
                  $display("FAIL unexpected_pulse cfg%0d: out_valid=1 at cycle %0d, required 0",
                           g, cyc);
               end else begin
                  e = q[g].pop_front();
                  if (oidx[g] != e.idx || omax[g] != e.mx) begin
                     n_bad++;
                     $display("FAIL result cfg%0d cycle %0d: idx=%0d max=%0d, required idx=%0d max=%0d",
                              g, cyc, oidx[g], omax[g], e.idx, e.mx);
                  end
                  last_idx[g] = e.idx;
                  last_mx[g]  = e.mx;
               end
            end else if (oidx[g] != last_idx[g] || omax[g] != last_mx[g]) begin
               n_bad++;
               $display("FAIL hold cfg%0d cycle %0d: idx=%0d max=%0d, required idx=%0d max=%0d",
                        g, cyc, oidx[g], omax[g], last_idx[g], last_mx[g]);
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         va[i] = '0;
         vb[i] = '0;
      end
      fill(0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Ascending: max at the last index for every class count.
      fill(0, 1, 100);
      send(1, 11, 111, 11, 111);
      idle(7);

      // Positive overflow: clamps with SAT, wraps negative without (all-zero tie -> idx 0).
      fill(0, 0, 0);
      na[3] = 16'(32767);
      nb[3] = 16'(10);
      send(1, 3, 32767, 0, 0);
      idle(7);

      // Negative values with a tie between indices 4 and 9.
      fill(-5, 0, 0);
      na[4] = 16'(-1);
      na[9] = 16'(-1);
      send(1, 4, -1, 4, -1);

      // Descending: max at index 0 (sent back-to-back with the previous vector).
      fill(0, -1, 100);
      send(1, 0, 100, 0, 100);

      // Negative overflow: all clamp to -32768 except element 6; wrapping gives 25536 everywhere else.
      fill(-20000, 0, -20000);
      na[6] = 16'(-100);
      nb[6] = 16'(0);
      send(1, 6, -100, 0, 25536);
      idle(7);

      // Streaming: 20 back-to-back, 3-cycle gap, 5 more.
      for (int k = 0; k < 20; k++) begin
         fill_rand();
         send(0, 0, 0, 0, 0);
      end
      idle(3);
      for (int k = 0; k < 5; k++) begin
         fill_rand();
         send(0, 0, 0, 0, 0);
      end
      idle(8);

      // Reset with vectors in flight.
      for (int k = 0; k < 3; k++) begin
         fill_rand();
         send(0, 0, 0, 0, 0);
      end
      idle(2);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(3);
      fill(0, 1, 100);
      send(1, 11, 111, 11, 111);
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
